// File: rtl/keyboard_msg_buffer.sv
// Line editor between the keyboard ASCII decoder and the laser transmitter:
// edits a line with backspace, commits it on Enter, and holds it for a valid/ack handshake.
module keyboard_msg_buffer #(
  parameter int          NCHARS   = 16,
  parameter logic [7:0]  PAD_CHAR = 8'h20,
  localparam int         LW       = $clog2(NCHARS + 1)
) (
  input  logic                  clock_65mhz,
  input  logic                  reset,
  input  logic [7:0]            ascii,
  input  logic                  ascii_ready,
  input  logic                  msg_ack,
  output logic [8*NCHARS-1:0]   edit_string,
  output logic [LW-1:0]         edit_len,
  output logic [8*NCHARS-1:0]   msg_string,
  output logic [LW-1:0]         msg_len,
  output logic                  msg_valid,
  output logic                  overflow,
  output logic                  rejected
);

  localparam logic [7:0]          CODE_BS    = 8'h08;
  localparam logic [7:0]          CODE_ENTER = 8'h0D;
  localparam logic [LW-1:0]       FULL_LEN   = LW'(NCHARS);
  localparam logic [8*NCHARS-1:0] PAD_LINE   = {NCHARS{PAD_CHAR}};

  typedef enum logic [1:0] {EDIT_EMPTY, EDIT_TYPING, EDIT_FULL} edit_state_t;
  typedef enum logic       {MSG_IDLE, MSG_PENDING}              msg_state_t;

  logic [8*NCHARS-1:0] edit_q, edit_d;
  logic [LW-1:0]       edit_len_q, edit_len_d;
  logic [8*NCHARS-1:0] msg_q, msg_d;
  logic [LW-1:0]       msg_len_q, msg_len_d;
  msg_state_t          msg_state_q, msg_state_d;
  logic                overflow_q, overflow_d;
  logic                rejected_q, rejected_d;

  edit_state_t edit_state;
  logic        is_bs, is_enter, is_print, commit;

  // The edit FSM is a view of edit_len rather than a separate register.
  always_comb begin
    if (edit_len_q == '0)            edit_state = EDIT_EMPTY;
    else if (edit_len_q == FULL_LEN) edit_state = EDIT_FULL;
    else                             edit_state = EDIT_TYPING;
  end

  assign is_bs    = ascii_ready && (ascii == CODE_BS);
  assign is_enter = ascii_ready && (ascii == CODE_ENTER);
  assign is_print = ascii_ready && !is_bs && !is_enter;
  // A pending message may be replaced only if it is being acknowledged this cycle.
  assign commit   = is_enter && (edit_state != EDIT_EMPTY) &&
                    ((msg_state_q == MSG_IDLE) || msg_ack);

  always_comb begin
    edit_d     = edit_q;
    edit_len_d = edit_len_q;
    overflow_d = 1'b0;
    rejected_d = 1'b0;
    if (commit) begin
      edit_d     = PAD_LINE;
      edit_len_d = '0;
    end else if (is_enter) begin
      rejected_d = 1'b1;
    end else if (is_print) begin
      if (edit_state == EDIT_FULL) begin
        overflow_d = 1'b1;
      end else begin
        for (int i = 0; i < NCHARS; i++) begin
          if (edit_len_q == LW'(i)) edit_d[8*(NCHARS-1-i) +: 8] = ascii;
        end
        edit_len_d = edit_len_q + 1'b1;
      end
    end else if (is_bs && (edit_state != EDIT_EMPTY)) begin
      for (int i = 0; i < NCHARS; i++) begin
        if (edit_len_q == LW'(i + 1)) edit_d[8*(NCHARS-1-i) +: 8] = PAD_CHAR;
      end
      edit_len_d = edit_len_q - 1'b1;
    end
  end

  always_comb begin
    msg_state_d = msg_state_q;
    msg_d       = msg_q;
    msg_len_d   = msg_len_q;
    if (commit) begin
      msg_d       = edit_q;
      msg_len_d   = edit_len_q;
      msg_state_d = MSG_PENDING;
    end else if (msg_ack && (msg_state_q == MSG_PENDING)) begin
      msg_state_d = MSG_IDLE;
    end
  end

  always_ff @(posedge clock_65mhz) begin
    if (reset) begin
      edit_q      <= PAD_LINE;
      edit_len_q  <= '0;
      msg_q       <= PAD_LINE;
      msg_len_q   <= '0;
      msg_state_q <= MSG_IDLE;
      overflow_q  <= 1'b0;
      rejected_q  <= 1'b0;
    end else begin
      edit_q      <= edit_d;
      edit_len_q  <= edit_len_d;
      msg_q       <= msg_d;
      msg_len_q   <= msg_len_d;
      msg_state_q <= msg_state_d;
      overflow_q  <= overflow_d;
      rejected_q  <= rejected_d;
    end
  end

  assign edit_string = edit_q;
  assign edit_len    = edit_len_q;
  assign msg_string  = msg_q;
  assign msg_len     = msg_len_q;
  assign msg_valid   = (msg_state_q == MSG_PENDING);
  assign overflow    = overflow_q;
  assign rejected    = rejected_q;

endmodule

// File: tb/tb_keyboard_msg_buffer.sv
// Scoreboard bench: two instances (16 and 4 characters) share stimulus and are
// checked every cycle against a line/message model built from the editing rules.
module tb_keyboard_msg_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ascii = 8'h00;
  logic       ascii_ready = 1'b0;
  logic       msg_ack = 1'b0;

  logic [127:0] a_es, a_ms;
  logic [4:0]   a_el, a_ml;
  logic         a_mv, a_ov, a_rj;
  logic [31:0]  b_es, b_ms;
  logic [2:0]   b_el, b_ml;
  logic         b_mv, b_ov, b_rj;

  always #5 clk = ~clk;

  keyboard_msg_buffer #(.NCHARS(16), .PAD_CHAR(8'h20)) dut16 (
    .clock_65mhz(clk), .reset(reset), .ascii(ascii), .ascii_ready(ascii_ready),
    .msg_ack(msg_ack), .edit_string(a_es), .edit_len(a_el), .msg_string(a_ms),
    .msg_len(a_ml), .msg_valid(a_mv), .overflow(a_ov), .rejected(a_rj));

  keyboard_msg_buffer #(.NCHARS(4), .PAD_CHAR(8'h20)) dut4 (
    .clock_65mhz(clk), .reset(reset), .ascii(ascii), .ascii_ready(ascii_ready),
    .msg_ack(msg_ack), .edit_string(b_es), .edit_len(b_el), .msg_string(b_ms),
    .msg_len(b_ml), .msg_valid(b_mv), .overflow(b_ov), .rejected(b_rj));

  typedef struct {
    logic [127:0] es;
    int           el;
    logic [127:0] ms;
    int           ml;
    bit           mv;
    bit           ov;
    bit           rj;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int total = 0;
  int bad = 0;

  // Reference state: the typed line and held message as character lists.
  logic [7:0] line_m [2][16];
  int         llen_m [2];
  logic [7:0] msg_m  [2][16];
  int         mlen_m [2];
  bit         mv_m   [2];
  bit         ov_m   [2];
  bit         rj_m   [2];

  function automatic int nch(input int k);
    return (k == 0) ? 16 : 4;
  endfunction

  function automatic logic [127:0] pack(input int k, input bit use_msg);
    logic [127:0] v;
    int n, len;
    logic [7:0] b;
    v = '0;
    n = nch(k);
    len = use_msg ? mlen_m[k] : llen_m[k];
    for (int i = 0; i < n; i++) begin
      if (i < len) b = use_msg ? msg_m[k][i] : line_m[k][i];
      else         b = 8'h20;
      v[8*(n-1-i) +: 8] = b;
    end
    return v;
  endfunction

  task automatic model_step(input int k, input bit r, input bit rdy,
                            input logic [7:0] a, input bit ack);
    bit was_valid, did_commit;
    ov_m[k] = 0;
    rj_m[k] = 0;
    if (r) begin
      llen_m[k] = 0;
      mlen_m[k] = 0;
      mv_m[k] = 0;
      return;
    end
    was_valid = mv_m[k];
    did_commit = 0;
    if (rdy) begin
      if (a == 8'h08) begin
        if (llen_m[k] > 0) llen_m[k]--;
      end else if (a == 8'h0D) begin
        if (llen_m[k] > 0 && (!was_valid || ack)) begin
          for (int i = 0; i < 16; i++) msg_m[k][i] = line_m[k][i];
          mlen_m[k] = llen_m[k];
          llen_m[k] = 0;
          mv_m[k] = 1;
          did_commit = 1;
        end else begin
          rj_m[k] = 1;
        end
      end else if (llen_m[k] < nch(k)) begin
        line_m[k][llen_m[k]] = a;
        llen_m[k]++;
      end else begin
        ov_m[k] = 1;
      end
    end
    if (!did_commit && ack && was_valid) mv_m[k] = 0;
  endtask

  task automatic cyc(input bit r, input bit rdy, input logic [7:0] a, input bit ack);
    exp_t e;
    @(negedge clk);
    reset = r;
    ascii_ready = rdy;
    ascii = a;
    msg_ack = ack;
    for (int k = 0; k < 2; k++) begin
      model_step(k, r, rdy, a, ack);
      e.es = pack(k, 0);
      e.el = llen_m[k];
      e.ms = pack(k, 1);
      e.ml = mlen_m[k];
      e.mv = mv_m[k];
      e.ov = ov_m[k];
      e.rj = rj_m[k];
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic key(input logic [7:0] a);
    cyc(0, 1, a, 0);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs for the edge just taken are compared shortly after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("n16 edit_string", a_es, e.es);
        chk("n16 edit_len", 128'(a_el), 128'(e.el));
        chk("n16 msg_string", a_ms, e.ms);
        chk("n16 msg_len", 128'(a_ml), 128'(e.ml));
        chk("n16 msg_valid", 128'(a_mv), 128'(e.mv));
        chk("n16 overflow", 128'(a_ov), 128'(e.ov));
        chk("n16 rejected", 128'(a_rj), 128'(e.rj));
        $display("n16 cyc t=%0t el=%0d ml=%0d mv=%0b ov=%0b rj=%0b",
                 $time, a_el, a_ml, a_mv, a_ov, a_rj);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("n4 edit_string", 128'(b_es), e.es);
        chk("n4 edit_len", 128'(b_el), 128'(e.el));
        chk("n4 msg_string", 128'(b_ms), e.ms);
        chk("n4 msg_len", 128'(b_ml), 128'(e.ml));
        chk("n4 msg_valid", 128'(b_mv), 128'(e.mv));
        chk("n4 overflow", 128'(b_ov), 128'(e.ov));
        chk("n4 rejected", 128'(b_rj), 128'(e.rj));
      end
    end
  end

  initial begin
    logic [7:0] a;
    int sel;
    for (int k = 0; k < 2; k++) begin
      llen_m[k] = 0; mlen_m[k] = 0; mv_m[k] = 0; ov_m[k] = 0; rj_m[k] = 0;
    end
    cyc(1, 0, 8'h00, 0);
    cyc(1, 0, 8'h00, 0);
    // "HI" + Enter, then acknowledge
    key(8'h48); key(8'h49); key(8'h0D);
    cyc(0, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 1);
    // edit with backspace, then backspace on an empty line
    key(8'h41); key(8'h42); key(8'h43); key(8'h08); key(8'h44); key(8'h0D);
    cyc(0, 0, 8'h00, 1);
    key(8'h08);
    // fill past capacity
    for (int i = 0; i < 17; i++) key(8'h61 + 8'(i));
    key(8'h0D);
    cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);
    // rejected Enters, then commit with same-cycle ack
    key(8'h0D);
    key(8'h58); key(8'h0D);
    key(8'h59); key(8'h0D);
    cyc(0, 1, 8'h0D, 1);
    cyc(0, 0, 8'h00, 0);
    // reset mid-line with a message pending; strobe during reset discarded
    key(8'h41); key(8'h42);
    cyc(1, 1, 8'h43, 0);
    cyc(0, 0, 8'h00, 0);
    key(8'h48); key(8'h49); key(8'h0D);
    cyc(0, 0, 8'h00, 0);
    // random traffic
    for (int n = 0; n < 800; n++) begin
      sel = $urandom_range(0, 11);
      if (sel < 2)       a = 8'h08;
      else if (sel == 2) a = 8'h0D;
      else               a = 8'($urandom_range(1, 255));
      cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0), a,
          ($urandom_range(0, 4) == 0));
    end
    cyc(0, 0, 8'h00, 0);
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d/%0d want=0/0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keyboard_msg_buffer.md
# keyboard_msg_buffer

Parametrised line editor between the PS/2 ASCII decoder and the laser transmitter. Accepts one-cycle ASCII strobes, builds an editable line of up to NCHARS characters with backspace support, and on Enter commits the line into a held message register. The message is offered to the transmitter by a valid/ack handshake. Generalises the fixed 16-character keyboard export block with configurable length, editing and explicit commit.

## Interface
- NCHARS, 16: maximum characters per line/message (≥2).
- PAD_CHAR, 8'h20: fill value of unused character slots.
- LW, $clog2(NCHARS+1): length field width (derived, not overridden).

- clock_65mhz  in  1  system clock; everything on rising edge.
- reset  in  1  synchronous, active-high.
- ascii  in  8  character code from keyboard decoder.
- ascii_ready  in  1  one-cycle strobe; ascii valid when high.
- msg_ack  in  1  transmitter has taken msg_string; sampled only while msg_valid=1.
- edit_string  out  8*NCHARS  line being typed (for display).
- edit_len  out  LW  characters currently in edit line, 0..NCHARS.
- msg_string  out  8*NCHARS  committed message.
- msg_len  out  LW  length of committed message, 1..NCHARS when valid.
- msg_valid  out  1  committed message pending transmission.
- overflow  out  1  one-cycle pulse: character dropped, line full.
- rejected  out  1  one-cycle pulse: Enter ignored (empty line or message pending).

## Operation
- Packing: character index i (0 = first typed) occupies bits [8*(NCHARS-1-i)+7 : 8*(NCHARS-1-i)]; first character in the most-significant byte. Slots ≥ length hold PAD_CHAR.
- Code classes on ascii_ready: 8'h08 backspace; 8'h0D enter; every other code (including 8'h23 from unmapped keys) printable.
- Printable, edit_len<NCHARS: write slot edit_len, edit_len+1.
- Printable, edit_len==NCHARS: no change, overflow=1.
- Backspace, edit_len>0: slot edit_len-1 ← PAD_CHAR, edit_len-1. edit_len==0: no change, no pulse.
- Enter, edit_len>0 and (msg_valid==0 or msg_ack==1): msg_string←edit_string, msg_len←edit_len, msg_valid=1; edit_string all PAD_CHAR, edit_len=0.
- Enter otherwise: no change, rejected=1. Edit line preserved.
- msg_ack with msg_valid=1 and no commit that cycle: msg_valid←0; msg_string/msg_len hold last value.
- msg_ack with msg_valid=0: ignored.
- Edit state machine (derived from edit_len): EMPTY (0) → TYPING (1..NCHARS-1) → FULL (NCHARS); backspace moves down, printable up, commit returns to EMPTY. Message FSM: IDLE ⇄ PENDING (commit sets, ack clears, commit+ack stays PENDING with new contents).
- ascii_ready low: inputs ignored.

## Timing
- All outputs registered; ascii_ready at cycle N → edit/msg outputs and pulses updated at edge ending cycle N (visible cycle N+1). Latency 1.
- overflow/rejected high exactly one cycle per offending strobe.
- Back-to-back strobes on consecutive cycles fully supported; no input buffering required.
- msg_string stable for entire time msg_valid=1 unless a same-cycle ack+commit replaces it.
- Reset (any time, including mid-line or message pending): edit_string and msg_string all PAD_CHAR, edit_len=0, msg_len=0, msg_valid=0, overflow=0, rejected=0; strobes during reset discarded.

## Test plan
- Type "HI" (8'h48, 8'h49) then 8'h0D, NCHARS=16 → msg_valid=1, msg_len=2, msg_string top bytes 48 49 then fourteen 20; edit_len=0.
- Type "ABC", backspace, "D", enter → msg_string starts 41 42 44, msg_len=3; backspace on empty line → no change, no pulse.
- 17 printable strobes NCHARS=16 → edit_len=16, 17th gives overflow=1 one cycle, slot 15 holds 16th char.
- Enter on empty line → rejected=1, msg_valid stays 0; enter while pending without ack → rejected=1, edit line intact.
- Pending "X", type "Y", enter with msg_ack same cycle → msg_valid stays 1, msg_string starts 59, msg_len=1.
- Reset asserted mid-line with message pending → all outputs to reset values next cycle; NCHARS=4 rerun of first scenario passes.
